// File: rtl/alu_src_b_stage.sv
// alu_src_b_stage: registered ALU source-B operand selector for the multicycle
// datapath. Builds the candidate operand combinationally from the select code
// (B, constant, extended immediate, shifted immediate, A, upper immediate).
// It presents the operand through a valid/ready output register backed by a
// one-entry skid buffer, so the ALU can stall without losing an operand.
// Illegal select codes produce a zero operand and set a sticky error flag.
// WIDTH must exceed IMM_W + 2 so every immediate form fits the operand.
module alu_src_b_stage #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       IMM_W     = 16,
  parameter logic [WIDTH-1:0]  CONST_VAL = 'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic             ext_sign,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] A,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             sel_err,
  input  logic             err_clr
);

  logic [WIDTH-1:0] extImm;
  logic [WIDTH-1:0] candidate;
  logic             candIllegal;

  logic             accept;
  logic             drain;

  logic [WIDTH-1:0] outData_q,   outData_d;
  logic             outValid_q,  outValid_d;
  logic [WIDTH-1:0] skidData_q,  skidData_d;
  logic             skidValid_q, skidValid_d;
  logic             selErr_q,    selErr_d;

  assign extImm = {{(WIDTH-IMM_W){ext_sign & imm[IMM_W-1]}}, imm};

  // Pick the candidate operand; the two spare codes yield zero and are flagged.
  always_comb begin
    candidate   = '0;
    candIllegal = 1'b0;
    case (sel)
      3'b000:  candidate = B;
      3'b001:  candidate = CONST_VAL;
      3'b010:  candidate = extImm;
      3'b011:  candidate = {extImm[WIDTH-3:0], 2'b00};
      3'b100:  candidate = A;
      3'b101:  candidate = {imm, {(WIDTH-IMM_W){1'b0}}};
      default: begin
        candidate   = '0;
        candIllegal = 1'b1;
      end
    endcase
  end

  // The stage only refuses input when the skid entry is occupied, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready = reset & ~skidValid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = outValid_q & out_ready;

  // Next-state for the main/skid pair: the skid entry always feeds the main
  // register first, which keeps delivery strictly in arrival order.
  always_comb begin
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    skidData_d  = skidData_q;
    skidValid_d = skidValid_q;

    if (drain) begin
      if (skidValid_q) begin
        outData_d   = skidData_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
        if (accept) begin
          skidData_d  = candidate;
          skidValid_d = 1'b1;
        end
      end else if (accept) begin
        outData_d  = candidate;
        outValid_d = 1'b1;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!outValid_q) begin
        outData_d  = candidate;
        outValid_d = 1'b1;
      end else begin
        skidData_d  = candidate;
        skidValid_d = 1'b1;
      end
    end
  end

  // Sticky error: an accepted illegal code takes priority over a clear request.
  always_comb begin
    selErr_d = selErr_q;
    if (accept && candIllegal) begin
      selErr_d = 1'b1;
    end else if (err_clr) begin
      selErr_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset discarding held operands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      skidData_q  <= '0;
      skidValid_q <= 1'b0;
      selErr_q    <= 1'b0;
    end else begin
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      skidData_q  <= skidData_d;
      skidValid_q <= skidValid_d;
      selErr_q    <= selErr_d;
    end
  end

  assign out       = outData_q;
  assign out_valid = outValid_q;
  assign sel_err   = selErr_q;

endmodule

// File: tb/tb_alu_src_b_stage.sv
// tb_alu_src_b_stage: directed stimulus with a queue-based scoreboard.
// The driver pushes the hand-computed operand whenever an input is accepted;
// an independent monitor pops and compares each time the ALU side drains.
module tb_alu_src_b_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic        ext_sign;
  logic [31:0] B;
  logic [31:0] A;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        sel_err;
  logic        err_clr;

  int total = 0;
  int bad   = 0;
  logic [31:0] sbQ[$];

  alu_src_b_stage #(.WIDTH(32), .IMM_W(16), .CONST_VAL(32'd4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .ext_sign(ext_sign), .B(B), .A(A), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; record the expected operand
  // if the stage will accept it at the coming rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] s,
                               input logic es, input logic [31:0] a,
                               input logic [31:0] b, input logic [15:0] im,
                               input logic ordy, input logic [31:0] expVal,
                               output logic acc);
    @(negedge clk);
    in_valid  = v;
    sel       = s;
    ext_sign  = es;
    A         = a;
    B         = b;
    imm       = im;
    out_ready = ordy;
    #1;
    acc = v & in_ready;
    if (acc) sbQ.push_back(expVal);
  endtask

  task automatic idle(input int n, input logic ordy);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = ordy;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  // Monitor: compare every drained operand against the scoreboard and check
  // that a stalled operand does not move.
  initial begin
    logic        prevHold;
    logic [31:0] prevOut;
    prevHold = 1'b0;
    prevOut  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (prevHold) checkOutput("stall_hold", out, prevOut);
      if (reset && out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_out", out, 32'hDEADBEEF);
        end else begin
          checkOutput("drain_data", out, sbQ.pop_front());
        end
      end
      prevHold = reset & out_valid & ~out_ready;
      prevOut  = out;
    end
  end

  initial begin
    logic acc;
    int   tries;
    logic [2:0]  s;
    logic [31:0] va, vb, ev;
    logic [15:0] vi;
    logic        vs;

    reset = 1'b0; in_valid = 1'b0; sel = 3'b000; ext_sign = 1'b0;
    A = '0; B = '0; imm = '0; out_ready = 1'b0; err_clr = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    settle();
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out", out, 32'd0);
    checkOutput("rst_sel_err", {31'b0, sel_err}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Select sweep with sign extension, streaming at full rate.
    applyStimulus(1, 3'b000, 1, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'h22222222, acc);
    applyStimulus(1, 3'b001, 1, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'h00000004, acc);
    applyStimulus(1, 3'b010, 1, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'hFFFF8001, acc);
    applyStimulus(1, 3'b011, 1, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'hFFFE0004, acc);
    applyStimulus(1, 3'b100, 1, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'h11111111, acc);
    applyStimulus(1, 3'b101, 1, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'h80010000, acc);
    // Zero extension.
    applyStimulus(1, 3'b010, 0, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'h00008001, acc);
    applyStimulus(1, 3'b011, 0, 32'h11111111, 32'h22222222, 16'h8001, 1, 32'h00020004, acc);
    idle(1, 1);
    #2;
    checkOutput("sweep_sel_err", {31'b0, sel_err}, 32'd0);
    idle(2, 1);

    // Back-pressure: fill main and skid, third request must be refused.
    applyStimulus(1, 3'b000, 0, 32'h0, 32'd5, 16'h0, 0, 32'd5, acc);
    checkOutput("bp_acc1", {31'b0, acc}, 32'd1);
    applyStimulus(1, 3'b100, 0, 32'd7, 32'h0, 16'h0, 0, 32'd7, acc);
    checkOutput("bp_acc2", {31'b0, acc}, 32'd1);
    applyStimulus(1, 3'b000, 0, 32'h0, 32'd9, 16'h0, 0, 32'd9, acc);
    checkOutput("bp_acc3", {31'b0, acc}, 32'd0);
    checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_out_held", out, 32'd5);
    idle(2, 1);
    settle();
    checkOutput("bp_empty", {31'b0, out_valid}, 32'd0);

    // Illegal selector handling.
    applyStimulus(1, 3'b110, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 1, 32'h0, acc);
    idle(1, 1);
    #2;
    checkOutput("ill_set", {31'b0, sel_err}, 32'd1);
    idle(1, 1);
    #2;
    checkOutput("ill_sticky", {31'b0, sel_err}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    checkOutput("ill_clear", {31'b0, sel_err}, 32'd0);
    err_clr = 1'b1;
    applyStimulus(1, 3'b111, 0, 32'h1, 32'h1, 16'h1, 1, 32'h0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    #2;
    checkOutput("ill_set_wins", {31'b0, sel_err}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    idle(2, 1);

    // Refused illegal code must not set the flag.
    applyStimulus(1, 3'b000, 0, 32'h0, 32'h33, 16'h0, 0, 32'h33, acc);
    applyStimulus(1, 3'b100, 0, 32'h44, 32'h0, 16'h0, 0, 32'h44, acc);
    applyStimulus(1, 3'b110, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0, acc);
    checkOutput("ill_refused_acc", {31'b0, acc}, 32'd0);
    settle();
    checkOutput("ill_refused_err", {31'b0, sel_err}, 32'd0);

    // Reset with both registers full.
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    sbQ.delete();
    #2;
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_rst_out", out, 32'd0);
    checkOutput("mid_rst_err", {31'b0, sel_err}, 32'd0);
    checkOutput("mid_rst_in_ready2", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Streaming with random back-pressure.
    for (int i = 0; i < 16; i++) begin
      va = 32'hC3000000 + i;
      vb = 32'h5A000000 + i;
      vi = 16'h8000 + 16'(i);
      vs = 1'b1;
      case (i % 3)
        0: begin s = 3'b000; ev = vb; end
        1: begin s = 3'b100; ev = va; end
        default: begin s = 3'b010; ev = 32'hFFFF8000 + i; end
      endcase
      tries = 0;
      do begin
        applyStimulus(1, s, vs, va, vb, vi, 1'($urandom_range(0, 1)), ev, acc);
        tries++;
      end while (!acc && tries < 100);
      if (!acc) checkOutput("stream_accept", {31'b0, acc}, 32'd1);
    end

    // Drain everything, bounded.
    tries = 0;
    idle(1, 1);
    while ((sbQ.size() != 0 || out_valid) && tries < 50) begin
      idle(1, 1);
      tries++;
    end
    settle();
    checkOutput("final_queue_empty", sbQ.size(), 32'd0);
    checkOutput("final_out_valid", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
